io_bus_arbiter: RTL and testbench
=================================

Name: io_bus_arbiter

Overview:
Shares the single IO peripheral port (addr/data/write/data_out) between NUM_REQ bus masters: CPU pst/pld path, debug loader, LED/display refresher. Each master uses a request/ack handshake. The arbiter latches the winner's command, drives the IO port for one cycle, captures read data and acks. Sits between the cores and the io block, on the same clock as the CPU.

Parameters:
NUM_REQ, 4, number of requesters (2..8); index 0 is the CPU
ADDR_W, 16, IO address width
DATA_W, 16, IO data width

Ports:
clk  in  1  system clock (same gated clock as CPU)
async_rst_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-master request; held high until ack
we  in  NUM_REQ  per-master write enable (1=write, 0=read); valid while req
addr  in  NUM_REQ*ADDR_W  flattened addresses; master i at [i*ADDR_W +: ADDR_W]
wdata  in  NUM_REQ*DATA_W  flattened write data, same packing
ack  out  NUM_REQ  one-hot, one-cycle completion pulse
rdata  out  DATA_W  shared read data; valid in ack cycle, held until next read completes
io_addr  out  ADDR_W  to io.addr
io_data  out  DATA_W  to io.data
io_write  out  1  to io.write
io_data_out  in  DATA_W  from io.data_out

Behaviour:
- Reset (async, active-low): state=IDLE, last=NUM_REQ-1, ack=0, rdata=0, io_addr=0, io_data=0, io_write=0.
- States: IDLE, ISSUE, COMPLETE.
- IDLE: if any eligible req, pick the winner round-robin, searching from last+1 upward with wrap. Latch idx, we, addr, wdata, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: for exactly one cycle, io_addr=latched addr, io_data=latched wdata, io_write=latched we. Then go to COMPLETE.
- COMPLETE:
  - io_write=0 (io_addr and io_data hold their values).
  - If the latched command is a read, rdata<=io_data_out.
  - ack[idx]=1 for this cycle only; last<=idx.
  - Same cycle: arbitrate among req with bit idx masked. If there is a winner, latch it and go to ISSUE (back-to-back). Otherwise go to IDLE.
- Latency: req high in IDLE to ack = 3 cycles. Sustained throughput is one transaction per 2 cycles.
- Master protocol:
  - req must stay high with stable we/addr/wdata until ack.
  - A master may drop req in the ack cycle or later.
  - req re-asserted in the cycle after ack is eligible.
  - Dropping req before ack is illegal; the latched command still completes and acks.
- Only one ack bit is high per cycle. Writes never alter rdata.
- Fairness: every continuously requesting master is served within NUM_REQ transactions.
- Reset mid-transaction: the transaction is abandoned, no ack is issued, and io_write drops immediately.
- All req low: the block idles with io_write=0.

Optional Feature:
IO_ARB_CPU_PRIO_EN:
- Defined: req[0] (CPU) wins every arbitration it participates in. Others rotate round-robin among themselves; last tracks only non-CPU grants.
- Undefined: pure round-robin over all masters.
- Reset values, latency and the handshake are identical in both builds.

Decomposition:
- Package io_arb_pkg holds:
  - ArbState enum (IDLE, ISSUE, COMPLETE)
  - default width localparams IO_ADDR_W=16, IO_DATA_W=16
  - function onehot_to_idx
- Sub-module rr_picker (combinational):
  - inputs: req vector, mask vector, last index
  - outputs: found, winner index
  - used in both IDLE and COMPLETE.

Test Plan:
- Single write: req[1]=1, we=1, addr=0x0002, wdata=0x00A5 -> io_write=1 with io_addr=0x0002, io_data=0x00A5 in cycle 2; ack[1] in cycle 3; rdata unchanged.
- Single read: req[0], we=0, addr=0x0004, io_data_out model returns 0x1234 -> ack[0] at cycle 3 with rdata=0x1234; io_write never asserted.
- Contention: req=4'b1111 held, each master re-requesting after ack -> ack order 0,1,2,3,0 with back-to-back ISSUE, ack every 2 cycles.
- Priority build (IO_ARB_CPU_PRIO_EN): req=4'b1110 held, pulse req[0] -> CPU acked next arbitration; others keep round-robin order 1,2,3.
- Reset in ISSUE: assert async_rst_n=0 while io_write=1 -> io_write, ack and rdata go to 0 asynchronously; after release, state is IDLE and the next grant goes to master 0.
- Illegal drop: req[2] dropped in ISSUE -> ack[2] still pulses in COMPLETE; no further grant to master 2.

Source files
------------

// File: rtl/io_arb_pkg.sv
// io_arb_pkg: state encoding, default IO widths and index helper shared by io_bus_arbiter.
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        COMPLETE = 2'd2
    } arb_state_t;

    localparam int IO_ADDR_W = 16;
    localparam int IO_DATA_W = 16;

    // Callers size-extend their one-hot vector to 8 bits (NUM_REQ never exceeds 8).
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin winner search starting after 'last', with a mask vector.
// With IO_ARB_CPU_PRIO_EN defined, requester 0 overrides and the rotation covers only 1..N-1.
module rr_picker
    import io_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] winner
);

    logic [N-1:0] elig;
    logic [N-1:0] rr_elig;
    logic [N-1:0] grant;

    assign elig = req & ~mask;

`ifdef IO_ARB_CPU_PRIO_EN
    assign rr_elig = elig & ~N'(1);
`else
    assign rr_elig = elig;
`endif

    // Walk from farthest to nearest so the closest eligible index after 'last' wins.
    always_comb begin
        int j;
        grant = '0;
        j     = 0;
        for (int k = N; k >= 1; k--) begin
            j = int'(last) + k;
            if (j >= N) j = j - N;
            if (rr_elig[j]) grant = N'(1) << j;
        end
`ifdef IO_ARB_CPU_PRIO_EN
        if (elig[0]) grant = N'(1);
`endif
    end

    assign found  = |grant;
    assign winner = IW'(onehot_to_idx(8'(grant)));

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares one IO port between NUM_REQ masters (0 = CPU) with round-robin grants.
// Handshake: a master holds req with stable we/addr/wdata until its one-cycle ack; build option IO_ARB_CPU_PRIO_EN.
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = IO_ADDR_W,
    parameter int DATA_W  = IO_DATA_W
) (
    input  logic                      clk,
    input  logic                      async_rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         io_addr,
    output logic [DATA_W-1:0]         io_data,
    output logic                      io_write,
    input  logic [DATA_W-1:0]         io_data_out,
    output arb_state_t                fsm_state
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state_q;
    arb_state_t         state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   last_q;
    logic               cmd_we_q;
    logic [NUM_REQ-1:0] pick_mask;
    logic               found;
    logic [IDX_W-1:0]   winner;
    logic               grant;
    logic               last_load;

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
    end

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_picker (
        .req    (req),
        .mask   (pick_mask),
        .last   (last_q),
        .found  (found),
        .winner (winner)
    );

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // The master being acked is masked so a held req cannot win twice in a row.
    always_comb begin
        state_d   = state_q;
        pick_mask = '0;
        grant     = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = COMPLETE;
            COMPLETE: begin
                pick_mask = NUM_REQ'(1) << idx_q;
                if (found) begin
                    grant   = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef IO_ARB_CPU_PRIO_EN
    assign last_load = grant && (winner != '0);
`else
    assign last_load = grant;
`endif

    // IO port registers double as the latched command; they load on the grant edge.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            idx_q    <= '0;
            last_q   <= IDX_W'(NUM_REQ - 1);
            cmd_we_q <= 1'b0;
            ack      <= '0;
            rdata    <= '0;
            io_addr  <= '0;
            io_data  <= '0;
            io_write <= 1'b0;
        end else begin
            ack      <= '0;
            io_write <= 1'b0;
            if (grant) begin
                idx_q    <= winner;
                cmd_we_q <= we[winner];
                io_addr  <= addr_arr[winner];
                io_data  <= wdata_arr[winner];
                io_write <= we[winner];
            end
            if (last_load) last_q <= winner;
            if (state_q == ISSUE) begin
                ack <= NUM_REQ'(1) << idx_q;
                if (!cmd_we_q) rdata <= io_data_out;
            end
        end
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed vector table, hand-written corner sequences and a randomized run
// against a transaction-level reference model of the arbiter.
module tb_io_bus_arbiter;
    import io_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic            clk;
    logic            async_rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   io_addr;
    logic [DW-1:0]   io_data;
    logic            io_write;
    logic [DW-1:0]   io_data_out;
    arb_state_t      fsm_state;

    logic [AW-1:0] m_addr  [N];
    logic [DW-1:0] m_wdata [N];

    int checks;
    int failures;

    io_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .ack         (ack),
        .rdata       (rdata),
        .io_addr     (io_addr),
        .io_data     (io_data),
        .io_write    (io_write),
        .io_data_out (io_data_out),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Peripheral model: combinational read data derived from the address.
    function automatic logic [DW-1:0] io_fn(input logic [AW-1:0] a);
        if (a == 16'h0004) return 16'h1234;
        return {a[7:0], ~a[7:0]};
    endfunction

    assign io_data_out = io_fn(io_addr);

    task automatic pack_bus();
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]  = m_addr[i];
            wdata[i*DW +: DW] = m_wdata[i];
        end
    endtask

    task automatic do_reset();
        async_rst_n = 1'b0;
        req = '0;
        we  = '0;
        for (int i = 0; i < N; i++) begin
            m_addr[i]  = '0;
            m_wdata[i] = '0;
        end
        pack_bus();
        repeat (2) @(posedge clk);
        #1 async_rst_n = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // ---------------- reference model ----------------
    int            md_busy;  // 2: command on the IO port, 1: ack cycle, 0: free
    int            md_cur;
    int            md_last;
    logic          md_cur_we;
    logic [N-1:0]  exp_ack;
    logic          exp_io_write;
    logic [AW-1:0] exp_io_addr;
    logic [DW-1:0] exp_io_data;
    logic [DW-1:0] exp_rdata;

    function automatic int pick(input logic [N-1:0] r, input int excl, input int last);
        int w;
        int j;
        w = -1;
        for (int k = 1; k <= N; k++) begin
            j = (last + k) % N;
            if (w < 0 && r[j] && j != excl) w = j;
        end
`ifdef IO_ARB_CPU_PRIO_EN
        if (r[0] && excl != 0) w = 0;
`endif
        return w;
    endfunction

    task automatic model_reset();
        md_busy      = 0;
        md_cur       = 0;
        md_last      = N - 1;
        md_cur_we    = 1'b0;
        exp_ack      = '0;
        exp_io_write = 1'b0;
        exp_io_addr  = '0;
        exp_io_data  = '0;
        exp_rdata    = '0;
    endtask

    task automatic model_edge();
        int w;
        exp_ack      = '0;
        exp_io_write = 1'b0;
        if (md_busy == 2) begin
            exp_ack[md_cur] = 1'b1;
            if (!md_cur_we) exp_rdata = io_fn(exp_io_addr);
            md_busy = 1;
        end else begin
            w = pick(req, (md_busy == 1) ? md_cur : -1, md_last);
            if (w >= 0) begin
                md_cur       = w;
                md_cur_we    = we[w];
                exp_io_addr  = m_addr[w];
                exp_io_data  = m_wdata[w];
                exp_io_write = we[w];
`ifdef IO_ARB_CPU_PRIO_EN
                if (w != 0) md_last = w;
`else
                md_last = w;
`endif
                md_busy = 2;
            end else begin
                md_busy = 0;
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic new_cmd(input int i);
        req[i]     = 1'b1;
        we[i]      = 1'($urandom_range(0, 1));
        m_addr[i]  = 16'($urandom_range(0, 255));
        m_wdata[i] = 16'($urandom);
    endtask

    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
                if ($urandom_range(0, 1) == 1) new_cmd(i);
                else req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                new_cmd(i);
            end
        end
        pack_bus();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int            m;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    logic [N-1:0] exp_q [$];
    int           exp_cyc_q [$];
    int           got_idx_q [$];
    int           got_cyc_q [$];

    initial begin
        logic [N-1:0] ack_or;
        logic         wr_or;
        checks   = 0;
        failures = 0;

        vecs[0] = '{1, 1'b1, 16'h0002, 16'h00A5, 16'h0000};
        vecs[1] = '{0, 1'b0, 16'h0004, 16'h0000, 16'h1234};
        vecs[2] = '{3, 1'b0, 16'h00C3, 16'h0000, 16'hC33C};
        vecs[3] = '{2, 1'b1, 16'h0010, 16'hFFFF, 16'hC33C};
        vecs[4] = '{2, 1'b0, 16'h0081, 16'h0000, 16'h817E};

        do_reset();
        check("reset_ack", 32'(ack), 32'h0);
        check("reset_io_write", 32'(io_write), 32'h0);
        check("reset_io_addr", 32'(io_addr), 32'h0);
        check("reset_io_data", 32'(io_data), 32'h0);
        check("reset_rdata", 32'(rdata), 32'h0);
        check("reset_state", 32'(fsm_state), 32'(IDLE));

        // Single transactions from idle: issue cycle, then ack cycle.
        for (int v = 0; v < 5; v++) begin
            req = '0;
            req[vecs[v].m]     = 1'b1;
            we[vecs[v].m]      = vecs[v].w;
            m_addr[vecs[v].m]  = vecs[v].a;
            m_wdata[vecs[v].m] = vecs[v].d;
            pack_bus();
            @(posedge clk);
            @(negedge clk);
            check("vec_issue_write", 32'(io_write), 32'(vecs[v].w));
            check("vec_issue_addr", 32'(io_addr), 32'(vecs[v].a));
            check("vec_issue_data", 32'(io_data), 32'(vecs[v].d));
            check("vec_issue_noack", 32'(ack), 32'h0);
            @(negedge clk);
            check("vec_ack", 32'(ack), 32'(1 << vecs[v].m));
            check("vec_complete_write", 32'(io_write), 32'h0);
            check("vec_rdata", 32'(rdata), 32'(vecs[v].exp_rdata));
            req = '0;
            @(posedge clk);
            #1;
        end

        // Contention: all masters hold req; acks every 2 cycles in rotation.
        do_reset();
        req = '1;
        we  = '0;
        for (int i = 0; i < N; i++) m_addr[i] = 16'h0100 + 16'(i);
        pack_bus();
`ifdef IO_ARB_CPU_PRIO_EN
        exp_q = '{4'd0, 4'd1, 4'd0, 4'd2, 4'd0};
`else
        exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
`endif
        exp_cyc_q = '{2, 4, 6, 8, 10};
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack != '0) begin
                got_idx_q.push_back(oh_idx(ack));
                got_cyc_q.push_back(cyc);
            end
        end
        check("contention_ack_count", 32'(got_idx_q.size()), 32'd6);
        for (int i = 0; i < 5; i++) begin
            if (i < got_idx_q.size()) begin
                check("contention_order", 32'(got_idx_q[i]), 32'(exp_q[i]));
                check("contention_cycle", 32'(got_cyc_q[i]), 32'(exp_cyc_q[i]));
            end else begin
                check("contention_missing_ack", 32'(i), 32'(got_idx_q.size() + 100));
            end
        end

        // Reset while a write is on the IO port.
        do_reset();
        req[3] = 1'b1;
        we[3]  = 1'b0;
        m_addr[3] = 16'h00C3;
        pack_bus();
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_rdata", 32'(rdata), 32'hC33C);
        req = '0;
        @(posedge clk);
        #1;
        req[1] = 1'b1;
        we[1]  = 1'b1;
        m_addr[1]  = 16'h0002;
        m_wdata[1] = 16'h5555;
        pack_bus();
        @(posedge clk);
        #2;
        check("issue_before_reset", 32'(io_write), 32'h1);
        async_rst_n = 1'b0;
        #1;
        check("async_reset_io_write", 32'(io_write), 32'h0);
        check("async_reset_ack", 32'(ack), 32'h0);
        check("async_reset_rdata", 32'(rdata), 32'h0);
        check("async_reset_state", 32'(fsm_state), 32'(IDLE));
        req = 4'b0011;
        we  = '0;
        m_addr[0] = 16'h0004;
        pack_bus();
        @(negedge clk);
        async_rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_grant_addr", 32'(io_addr), 32'h0004);
        @(negedge clk);
        check("post_reset_grant_ack", 32'(ack), 32'h1);
        req = '0;
        repeat (2) @(posedge clk);
        #1;

        // Illegal drop during issue: the latched command still acks, then nothing.
        req[2] = 1'b1;
        we[2]  = 1'b1;
        m_addr[2]  = 16'h0020;
        m_wdata[2] = 16'hBEEF;
        pack_bus();
        @(posedge clk);
        #1 req[2] = 1'b0;
        @(negedge clk);
        check("drop_issue_write", 32'(io_write), 32'h1);
        @(negedge clk);
        check("drop_still_acked", 32'(ack), 32'h4);
        ack_or = '0;
        wr_or  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ack_or = ack_or | ack;
            wr_or  = wr_or | io_write;
        end
        check("drop_no_regrant_ack", 32'(ack_or), 32'h0);
        check("drop_no_regrant_write", 32'(wr_or), 32'h0);
        check("drop_idle_state", 32'(fsm_state), 32'(IDLE));

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            model_edge();
            #1;
            drive_random();
            @(negedge clk);
            check("rand_ack", 32'(ack), 32'(exp_ack));
            check("rand_io_write", 32'(io_write), 32'(exp_io_write));
            check("rand_io_addr", 32'(io_addr), 32'(exp_io_addr));
            check("rand_io_data", 32'(io_data), 32'(exp_io_data));
            check("rand_rdata", 32'(rdata), 32'(exp_rdata));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
